// File: rtl/softmax_pipe_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pipe_pkg
//   Shared defaults for the softmax pipe flow controller: datapath width,
//   datapath latency, and the width of the occupancy counter.
//   occ_w(lat) gives the counter width for a credit limit of lat+1. The counter
//   must be able to hold the value lat+1, so it needs clog2(lat+2) bits.
// -----------------------------------------------------------------------------
package softmax_pipe_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_LAT   = 3;

   function automatic int occ_w(input int lat);
      return $clog2(lat + 2);
   endfunction

   localparam int DEF_OCC_W = occ_w(DEF_LAT);

endpackage

// File: rtl/softmax_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// softmax_pipe_ctrl_if
//   Upstream (s_*) and downstream (m_*) valid/ready channels of the softmax
//   pipe flow controller.
//   master : the environment side. It drives s_valid, s_data and m_ready.
//   slave  : the controller side. It drives s_ready, m_valid and m_data.
// -----------------------------------------------------------------------------
interface softmax_pipe_ctrl_if
   import softmax_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (output s_valid, s_data, m_ready,
                   input  s_ready, m_valid, m_data);

   modport slave  (input  s_valid, s_data, m_ready,
                   output s_ready, m_valid, m_data);
endinterface

// File: rtl/softmax_skid_fifo.sv
// -----------------------------------------------------------------------------
// softmax_skid_fifo
//   Small synchronous FIFO. The head entry is always a register, so dout
//   needs no read mux. On a pop, every entry moves one place toward the head.
//   A push and a pop in the same cycle are both honoured, including when the
//   FIFO is full. The pushed word lands behind the entries that remain.
//   Ports:
//     clk, rst      rising-edge clock, synchronous active-high reset
//     push, din     write request and data (ignored when full without a pop)
//     pop           read request (ignored when empty)
//     dout, valid   head entry and not-empty flag
//     count         number of stored entries
// -----------------------------------------------------------------------------
module softmax_skid_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;
   logic             full;
   logic             do_pop;
   logic             do_push;
   logic [CW-1:0]    wr_idx;

   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop & (cnt != '0);
   assign do_push = push & (~full | do_pop);
   // When a pop happens in the same cycle, the tail slot moves down by one.
   assign wr_idx  = do_pop ? cnt - 1'b1 : cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         // NOTE: the storage is reset here on purpose. The head register
         // drives m_data directly, and m_data must read 0 after reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: all state uses non-blocking assignments. The shift below
         // therefore reads the old contents, and the tail write that follows
         // it wins for its own slot.
         if (do_pop)
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
         for (int i = 0; i < DEPTH; i++)
            if (do_push && wr_idx == CW'(i)) mem[i] <= din;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign dout  = mem[0];
   assign valid = (cnt != '0);
   assign count = cnt;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !do_pop));
endmodule

// File: rtl/softmax_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// softmax_pipe_ctrl
//   Valid/ready wrapper around a free-running delay datapath that has LAT
//   stages and no enable. A valid shift register follows each token through
//   the datapath. A skid FIFO of DEPTH=LAT+1 entries catches the datapath
//   output. An occupancy credit (tokens in flight plus tokens buffered)
//   throttles upstream, so a downstream stall can never cause a drop.
//   Ports:
//     clk, rst     rising-edge clock, synchronous active-high reset
//     bus          slave side of softmax_pipe_ctrl_if (s_* in, m_* out)
//     dp_din       to the datapath input, combinational copy of s_data
//     dp_dout      from the datapath output, LAT cycles after dp_din
//     occupancy    tokens in flight plus tokens in the FIFO
//     stat_tokens  pop count             (only with SOFTMAX_PIPE_CTRL_STATS_EN)
//     stat_stall   cycles of s_valid & ~s_ready (only with SOFTMAX_PIPE_CTRL_STATS_EN)
//   s_ready looks only at the registered occupancy. There is no combinational
//   path from m_ready. A full credit window therefore costs one upstream
//   bubble, because the slot freed by a pop is visible one cycle later.
// -----------------------------------------------------------------------------
module softmax_pipe_ctrl
   import softmax_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAT   = DEF_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   softmax_pipe_ctrl_if.slave       bus,
   output logic [WIDTH-1:0]         dp_din,
   input  logic [WIDTH-1:0]         dp_dout,
   output logic [occ_w(LAT)-1:0]    occupancy
`ifdef SOFTMAX_PIPE_CTRL_STATS_EN
   ,
   output logic [31:0]              stat_tokens,
   output logic [31:0]              stat_stall
`endif
);
   localparam int                DEPTH   = LAT + 1;
   localparam int                OCC_W   = occ_w(LAT);
   localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(DEPTH);

   logic [LAT-1:0]   vld_sr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] fifo_count;
   logic             accept;
   logic             pop;

   assign bus.s_ready = (occ < DEPTH_C);
   assign accept      = bus.s_valid & bus.s_ready;
   assign pop         = bus.m_valid & bus.m_ready;
   assign dp_din      = bus.s_data;
   assign occupancy   = occ;

   // The datapath never stalls, so the valid tags shift every cycle. On
   // reset, whatever is still inside the datapath loses its tag and is
   // never captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
         occ    <= '0;
      end else begin
         vld_sr[0] <= accept;
         for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
         case ({accept, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   softmax_skid_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vld_sr[LAT-1]),
      .din   (dp_dout),
      .pop   (bus.m_ready),
      .dout  (bus.m_data),
      .valid (bus.m_valid),
      .count (fifo_count)
   );

`ifdef SOFTMAX_PIPE_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_tokens <= '0;
         stat_stall  <= '0;
      end else begin
         if (pop)                          stat_tokens <= stat_tokens + 32'd1;
         if (bus.s_valid && !bus.s_ready)  stat_stall  <= stat_stall + 32'd1;
      end
   end
`endif

   a_occ_limit: assert property (@(posedge clk) disable iff (rst)
      occ <= DEPTH_C);
   a_fifo_within_credit: assert property (@(posedge clk) disable iff (rst)
      fifo_count <= occ);
endmodule
